gpu_data_mem_responder: RTL and testbench

// - Memory-side responder for the GPU data-memory channels: serves per-channel read/write valid/ready

---
 rtl/gpu_data_mem_responder_pkg.sv | 15 +
 rtl/gpu_data_mem_responder_rr_arbiter.sv | 52 +++++
 rtl/gpu_data_mem_responder.sv | 143 ++++++++++++++
 tb/tb_gpu_data_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gpu_data_mem_responder_pkg.sv
// Shared definitions for the GPU data-memory responder.
// - Default widths and channel count used as parameter defaults.
// - Request kind encoding for the single RAM port.
package gpu_data_mem_responder_pkg;

    localparam int DEF_ADDR_BITS    = 12;
    localparam int DEF_DATA_BITS    = 16;
    localparam int DEF_NUM_CHANNELS = 4;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

endpackage

// File: rtl/gpu_data_mem_responder_rr_arbiter.sv
// N-way round-robin arbiter.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   req_i           per-requester request (already masked by caller)
//   block_i         suppress any grant this cycle (higher-priority user owns the resource)
//   grant_o         one-hot grant
//   idx_o           index of granted requester
//   valid_o         a grant was issued
// The pointer holds the last granted index; the search starts one past it.
module gpu_data_mem_responder_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N-1:0]     req_i,
    input  logic             block_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(ptr_q) + i) % N;
            if (!valid_o && !block_i && req_i[IDX_W'(cand)]) begin
                valid_o                  = 1'b1;
                grant_o[IDX_W'(cand)]    = 1'b1;
                idx_o                    = IDX_W'(cand);
            end
        end
    end

    // Pointer only moves on an actual grant, so a blocked cycle keeps fairness.
    always_comb begin
        ptr_d = ptr_q;
        if (valid_o) ptr_d = idx_o;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) ptr_q <= IDX_W'(N - 1);
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/gpu_data_mem_responder.sv
// Memory-side responder for the GPU data-memory channels.
// Serves per-channel read/write valid/ready requests out of one single-port RAM;
// a host port (load/dump) takes absolute priority over the GPU channels.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   data_mem_read_valid/address    per-channel read request (held until ready)
//   data_mem_read_ready/data       one-cycle done pulse, data valid with it and held after
//   data_mem_write_valid/address/data  per-channel write request
//   data_mem_write_ready           one-cycle write-done pulse
//   host_en/we/addr/wdata          host access, one per cycle
//   host_rdata/rvalid              host read response, one cycle after the access
module gpu_data_mem_responder
    import gpu_data_mem_responder_pkg::*;
#(
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           data_mem_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] data_mem_read_address,
    output logic [NUM_CHANNELS-1:0]           data_mem_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] data_mem_read_data,
    input  logic [NUM_CHANNELS-1:0]           data_mem_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] data_mem_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] data_mem_write_data,
    output logic [NUM_CHANNELS-1:0]           data_mem_write_ready,
    input  logic                              host_en,
    input  logic                              host_we,
    input  logic [ADDR_BITS-1:0]              host_addr,
    input  logic [DATA_BITS-1:0]              host_wdata,
    output logic [DATA_BITS-1:0]              host_rdata,
    output logic                              host_rvalid
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [DATA_BITS-1:0] mem_q [0:(1<<ADDR_BITS)-1];
    logic [DATA_BITS-1:0] ram_rdata_q;

    logic [NUM_CHANNELS-1:0] rd_ready_q, rd_ready_d;
    logic [NUM_CHANNELS-1:0] wr_ready_q, wr_ready_d;
    logic                    host_rvalid_q, host_rvalid_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_hold_q;
    logic [DATA_BITS-1:0]    host_hold_q;

    logic [NUM_CHANNELS-1:0] eligible, grant_oh;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_vld;
    req_kind_e               g_kind;

    logic                    ram_en, ram_we;
    logic [ADDR_BITS-1:0]    ram_addr;
    logic [DATA_BITS-1:0]    ram_wdata;

    // A channel whose ready is pulsing this cycle is masked: the GPU still
    // shows valid in that cycle and must not be served twice.
    assign eligible = (data_mem_read_valid | data_mem_write_valid) & ~rd_ready_q & ~wr_ready_q;

    gpu_data_mem_responder_rr_arbiter #(
        .N     (NUM_CHANNELS),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk_i   (clk),
        .reset_i (reset),
        .req_i   (eligible),
        .block_i (host_en),
        .grant_o (grant_oh),
        .idx_o   (grant_idx),
        .valid_o (grant_vld)
    );

    // Write wins when a channel asks for both; the read is picked up on a later grant.
    assign g_kind = data_mem_write_valid[grant_idx] ? REQ_WRITE : REQ_READ;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        if (host_en) begin
            ram_en = 1'b1;
            ram_we = host_we;
        end else if (grant_vld) begin
            ram_en    = 1'b1;
            ram_we    = (g_kind == REQ_WRITE);
            ram_addr  = (g_kind == REQ_WRITE)
                      ? data_mem_write_address[grant_idx*ADDR_BITS +: ADDR_BITS]
                      : data_mem_read_address[grant_idx*ADDR_BITS +: ADDR_BITS];
            ram_wdata = data_mem_write_data[grant_idx*DATA_BITS +: DATA_BITS];
        end
        if (reset) ram_en = 1'b0;
    end

    // Plain single-port RAM, no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem_q[ram_addr] <= ram_wdata;
            else        ram_rdata_q     <= mem_q[ram_addr];
        end
    end

    always_comb begin
        rd_ready_d    = '0;
        wr_ready_d    = '0;
        host_rvalid_d = host_en & ~host_we;
        if (grant_vld) begin
            if (g_kind == REQ_WRITE) wr_ready_d = grant_oh;
            else                     rd_ready_d = grant_oh;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ready_q    <= '0;
            wr_ready_q    <= '0;
            host_rvalid_q <= 1'b0;
            rd_hold_q     <= '0;
            host_hold_q   <= '0;
        end else begin
            rd_ready_q    <= rd_ready_d;
            wr_ready_q    <= wr_ready_d;
            host_rvalid_q <= host_rvalid_d;
            for (int c = 0; c < NUM_CHANNELS; c++)
                if (rd_ready_q[c]) rd_hold_q[c] <= ram_rdata_q;
            if (host_rvalid_q) host_hold_q <= ram_rdata_q;
        end
    end

    // The RAM output register carries the fresh word during the ready cycle;
    // the hold registers keep it visible until the channel's next read.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_rd_out
        assign data_mem_read_data[c*DATA_BITS +: DATA_BITS] =
            rd_ready_q[c] ? ram_rdata_q : rd_hold_q[c];
    end

    assign data_mem_read_ready  = rd_ready_q;
    assign data_mem_write_ready = wr_ready_q;
    assign host_rvalid          = host_rvalid_q;
    assign host_rdata           = host_rvalid_q ? ram_rdata_q : host_hold_q;

endmodule

// File: tb/tb_gpu_data_mem_responder.sv
module tb_gpu_data_mem_responder;

    localparam int AB = 12;
    localparam int DB = 16;
    localparam int NC = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     rv, rr, wv, wr;
    logic [NC*AB-1:0]  ra, wa;
    logic [NC*DB-1:0]  rd, wd;
    logic              h_en, h_we, h_rvalid;
    logic [AB-1:0]     h_addr;
    logic [DB-1:0]     h_wdata, h_rdata;

    int checks = 0;
    int failures = 0;

    gpu_data_mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .data_mem_read_valid    (rv),
        .data_mem_read_address  (ra),
        .data_mem_read_ready    (rr),
        .data_mem_read_data     (rd),
        .data_mem_write_valid   (wv),
        .data_mem_write_address (wa),
        .data_mem_write_data    (wd),
        .data_mem_write_ready   (wr),
        .host_en                (h_en),
        .host_we                (h_we),
        .host_addr              (h_addr),
        .host_wdata             (h_wdata),
        .host_rdata             (h_rdata),
        .host_rvalid            (h_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          we;
        logic [AB-1:0] addr;
        logic [DB-1:0] wdata;
        logic          exp_rv;
        logic [DB-1:0] exp_rd;
    } hvec_t;

    hvec_t hv [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int c, input logic [AB-1:0] a);
        rv[c] = 1'b1;
        ra[c*AB +: AB] = a;
    endtask

    task automatic set_wr(input int c, input logic [AB-1:0] a, input logic [DB-1:0] d);
        wv[c] = 1'b1;
        wa[c*AB +: AB] = a;
        wd[c*DB +: DB] = d;
    endtask

    function automatic logic [DB-1:0] rdat(input int c);
        return rd[c*DB +: DB];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic host_read(input logic [AB-1:0] a, input logic [DB-1:0] exp, input string nm);
        h_en = 1'b1; h_we = 1'b0; h_addr = a;
        step();
        h_en = 1'b0;
        chk({nm, "_rvalid"}, 32'(h_rvalid), 32'd1);
        chk({nm, "_rdata"}, 32'(h_rdata), 32'(exp));
    endtask

    initial begin
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        h_en = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        do_reset();

        // Reset state
        chk("rst_rready", 32'(rr), 32'd0);
        chk("rst_wready", 32'(wr), 32'd0);
        chk("rst_rdata", rd[31:0], 32'd0);
        chk("rst_rdata_hi", rd[63:32], 32'd0);
        chk("rst_hrvalid", 32'(h_rvalid), 32'd0);
        chk("rst_hrdata", 32'(h_rdata), 32'd0);

        // Host load/dump table; rdata holds the last host read word
        hv[0] = '{1'b1, 1'b1, 12'h010, 16'hBEEF, 1'b0, 16'h0000};
        hv[1] = '{1'b1, 1'b1, 12'hFFF, 16'h1234, 1'b0, 16'h0000};
        hv[2] = '{1'b1, 1'b1, 12'h000, 16'hA5A5, 1'b0, 16'h0000};
        hv[3] = '{1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 16'hBEEF};
        hv[4] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 1'b1, 16'h1234};
        hv[5] = '{1'b1, 1'b0, 12'h000, 16'h0000, 1'b1, 16'hA5A5};
        hv[6] = '{1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 16'hA5A5};
        for (int i = 0; i < 7; i++) begin
            h_en = hv[i].en; h_we = hv[i].we; h_addr = hv[i].addr; h_wdata = hv[i].wdata;
            step();
            chk($sformatf("host%0d_rvalid", i), 32'(h_rvalid), 32'(hv[i].exp_rv));
            chk($sformatf("host%0d_rdata", i), 32'(h_rdata), 32'(hv[i].exp_rd));
            chk($sformatf("host%0d_gpu_idle", i), 32'(rr | wr), 32'd0);
        end
        h_en = 1'b0;

        // Single read on ch2, valid held one extra cycle
        set_rd(2, 12'h010);
        step();
        chk("rd_ready_pulse", 32'(rr), 32'b0100);
        chk("rd_data", 32'(rdat(2)), 32'hBEEF);
        step();
        chk("rd_no_double", 32'(rr), 32'd0);
        rv = '0;
        step();
        chk("rd_idle", 32'(rr), 32'd0);
        chk("rd_data_hold", 32'(rdat(2)), 32'hBEEF);

        // Write then read, then host dump
        set_wr(0, 12'h123, 16'h5A5A);
        step();
        chk("wr_ready", 32'(wr), 32'b0001);
        chk("wr_no_rready", 32'(rr), 32'd0);
        wv = '0;
        set_rd(1, 12'h123);
        step();
        chk("wr_rd_ready", 32'(rr), 32'b0010);
        chk("wr_rd_data", 32'(rdat(1)), 32'h5A5A);
        rv = '0;
        host_read(12'h123, 16'h5A5A, "wr_host");

        // Fairness: all channels request continuously
        do_reset();
        for (int c = 0; c < NC; c++) set_rd(c, 12'h010);
        for (int k = 0; k < 8; k++) begin
            logic [NC-1:0] exp_oh;
            exp_oh = '0;
            exp_oh[k % NC] = 1'b1;
            step();
            chk($sformatf("rr_order%0d", k), 32'(rr), 32'(exp_oh));
        end
        rv = '0;
        step();
        step();

        // Host priority over a pending ch3 write
        set_wr(3, 12'h200, 16'h7777);
        h_en = 1'b1; h_we = 1'b0; h_addr = 12'h010;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("hp_wait%0d", k), 32'(wr), 32'd0);
            chk($sformatf("hp_hrvalid%0d", k), 32'(h_rvalid), 32'd1);
        end
        h_en = 1'b0;
        step();
        chk("hp_wr_after", 32'(wr), 32'b1000);
        wv = '0;
        step();
        host_read(12'h200, 16'h7777, "hp_host");

        // Same channel read+write: write first, read sees new word
        set_wr(2, 12'h300, 16'hC3C3);
        set_rd(2, 12'h300);
        step();
        chk("rw_wr_first", 32'(wr), 32'b0100);
        chk("rw_no_rd", 32'(rr), 32'd0);
        wv = '0;
        step();
        chk("rw_masked", 32'(rr | wr), 32'd0);
        step();
        chk("rw_rd_ready", 32'(rr), 32'b0100);
        chk("rw_rd_data", 32'(rdat(2)), 32'hC3C3);
        rv = '0;
        step();

        // Reset over a granted read: no pulse, pointer restarts at ch0
        set_rd(1, 12'h010);
        reset = 1'b1;
        step();
        chk("rst_mid_ready", 32'(rr), 32'd0);
        chk("rst_mid_data", 32'(rdat(2)), 32'd0);
        reset = 1'b0;
        rv = '0;
        step();
        chk("rst_mid_quiet", 32'(rr), 32'd0);
        set_rd(0, 12'h010);
        set_rd(2, 12'h123);
        step();
        chk("rst_ch0_first", 32'(rr), 32'b0001);
        chk("rst_ch0_data", 32'(rdat(0)), 32'hBEEF);
        rv[0] = 1'b0;
        step();
        chk("rst_ch2_next", 32'(rr), 32'b0100);
        chk("rst_ch2_data", 32'(rdat(2)), 32'h5A5A);
        rv = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
